// File: rtl/bcd_pkg.sv
// Shared types and helpers for the sequential binary-to-BCD converter.
//   b2b_state_t : converter FSM states
//   BCD_BLANK   : nibble code the seven-segment decoders render as all-off
//   digits_for  : minimum decimal digits needed for a bin_w-bit unsigned value
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } b2b_state_t;

  localparam logic [3:0] BCD_BLANK = 4'hF;

  // ceil(bin_w * log10(2)) with log10(2) held as 0.301029996 scaled by 1e9.
  // bin_w*log10(2) is never an integer for bin_w >= 1, so the smallest d with
  // d*1e9 >= product is the ceiling. Scanning downward leaves the smallest hit.
  function automatic int digits_for(input int bin_w);
    longint prod;
    int     res;
    prod = longint'(bin_w) * 64'sd301029996;
    res  = 1;
    for (int d = bin_w; d >= 1; d--) begin
      if (longint'(d) * 64'sd1000000000 >= prod) res = d;
    end
    return res;
  endfunction

endpackage

// File: rtl/bcd_add3_cell.sv
// One double-dabble correction cell: a BCD digit of 5 or more gets +3 so the
// following left shift carries correctly into the next digit.
//   din  : current 4-bit digit
//   dout : corrected digit (4-bit, wraps mod 16)
module bcd_add3_cell (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-add-3 converter, unsigned binary -> packed BCD, one bit per
// cycle. Leading-zero digits can be blanked to BCD_BLANK for the downstream
// seven-segment decoders. One conversion in flight, valid/ready on both sides.
//   clk, rst            : clock (rising), async active-high reset
//   in_valid/in_ready   : input handshake; in_ready high only while idle
//   in_bin   [BIN_W]    : value to convert, sampled at the accepting edge
//   out_valid/out_ready : output handshake; result held until taken
//   out_bcd  [4*DIGITS] : digit k at [4k+3:4k], digit 0 = units
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int BIN_W    = 16,
  parameter int DIGITS   = 5,
  parameter bit LZ_BLANK = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BIN_W-1:0]      in_bin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_bcd
);

  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam int BCD_W = 4 * DIGITS;

  if (DIGITS < digits_for(BIN_W)) begin : g_bad_digits
    $error("bin_to_bcd_seq: DIGITS=%0d too small for BIN_W=%0d", DIGITS, BIN_W);
  end

  b2b_state_t state_q, state_d;

  logic [BIN_W-1:0]        bin_q;
  logic [DIGITS-1:0][3:0]  acc_q;
  logic [DIGITS-1:0][3:0]  acc_adj;
  logic [DIGITS-1:0][3:0]  acc_shf;
  logic [DIGITS-1:0][3:0]  acc_blk;
  logic [BCD_W-1:0]        adj_flat;
  logic [CNT_W-1:0]        cnt_q;
  logic                    out_valid_q;
  logic [BCD_W-1:0]        out_bcd_q;
  logic                    load, step, last, take;
  logic                    unused_adj_top;

  // ---- per-digit correction ----
  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3_cell u_add3 (
      .din  (acc_q[g]),
      .dout (acc_adj[g])
    );
  end

  // Corrected digits shift left one, pulling in the binary MSB. The top bit
  // falls off; it is always zero when DIGITS meets the minimum.
  assign adj_flat       = acc_adj;
  assign acc_shf        = {adj_flat[BCD_W-2:0], bin_q[BIN_W-1]};
  assign unused_adj_top = adj_flat[BCD_W-1];

  // ---- leading-zero blanking: priority chain from the MS digit down ----
  // lz[k] is set when digit k and every digit above it are zero.
  logic [DIGITS:1] lz;
  assign lz[DIGITS] = 1'b1;
  assign acc_blk[0] = acc_shf[0];
  for (genvar g = 1; g < DIGITS; g++) begin : g_blank
    assign lz[g]      = lz[g+1] & (acc_shf[g] == 4'd0);
    assign acc_blk[g] = (LZ_BLANK && lz[g]) ? BCD_BLANK : acc_shf[g];
  end

  // ---- FSM ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    last    = 1'b0;
    take    = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          load    = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        step = 1'b1;
        if (cnt_q == CNT_W'(BIN_W - 1)) begin
          last    = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          take    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready = (state_q == IDLE);

  // ---- datapath ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_q       <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_bcd_q   <= '0;
    end else begin
      if (load) begin
        bin_q <= in_bin;
        acc_q <= '0;
        cnt_q <= '0;
      end else if (step) begin
        bin_q <= bin_q << 1;
        acc_q <= acc_shf;
        cnt_q <= cnt_q + CNT_W'(1);
      end
      // Final shift result goes straight to the output register, so
      // out_valid rises on the BIN_W-th shift edge.
      if (last) begin
        out_bcd_q   <= acc_blk;
        out_valid_q <= 1'b1;
      end else if (take) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_bcd   = out_bcd_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
module tb_bin_to_bcd_seq;

  typedef struct {
    logic [15:0] bin;
    logic [19:0] b;   // expected, blanking on
    logic [19:0] p;   // expected, blanking off
  } vec_t;

  logic        clk, rst;
  logic        in_valid, out_ready;
  logic [15:0] in_bin;
  logic        in_ready_b, out_valid_b, in_ready_p, out_valid_p;
  logic [19:0] out_bcd_b, out_bcd_p;

  bin_to_bcd_seq #(.BIN_W(16), .DIGITS(5), .LZ_BLANK(1'b1)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_bin(in_bin), .out_valid(out_valid_b), .out_ready(out_ready),
    .out_bcd(out_bcd_b));

  bin_to_bcd_seq #(.BIN_W(16), .DIGITS(5), .LZ_BLANK(1'b0)) dut_p (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_p),
    .in_bin(in_bin), .out_valid(out_valid_p), .out_ready(out_ready),
    .out_bcd(out_bcd_p));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  bit   prev_ov = 1'b0;
  vec_t sb[$];
  int   acc_q[$];
  logic [19:0] last_b, last_p;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: decimal digits by division, then blank leading zeros above units.
  function automatic logic [19:0] model(input int v, input bit blank);
    logic [19:0] r;
    int x = v;
    bit lead = 1'b1;
    for (int k = 0; k < 5; k++) begin
      r[4*k +: 4] = 4'(x % 10);
      x = x / 10;
    end
    if (blank) begin
      for (int k = 4; k >= 1; k--) begin
        if (lead && r[4*k +: 4] == 4'd0) r[4*k +: 4] = 4'hF;
        else lead = 1'b0;
      end
    end
    return r;
  endfunction

  // One clock: sample handshakes before the edge, update scoreboard after it.
  task automatic tick();
    bit hs_in, hs_out;
    logic [15:0] b;
    logic [19:0] ob, op;
    vec_t e;
    hs_in  = !rst && in_valid && in_ready_b;
    hs_out = !rst && out_valid_b && out_ready;
    b  = in_bin;
    ob = out_bcd_b;
    op = out_bcd_p;
    @(posedge clk);
    #1;
    cyc++;
    if (hs_in) begin
      e.bin = b; e.b = model(int'(b), 1'b1); e.p = model(int'(b), 1'b0);
      sb.push_back(e);
      acc_cyc = cyc;
      acc_q.push_back(cyc);
    end
    if (hs_out) begin
      if (sb.size() == 0) begin
        chk("unexpected_output", {12'd0, ob}, 32'hDEAD);
      end else begin
        e = sb.pop_front();
        chk("sb_blank", {12'd0, ob}, {12'd0, e.b});
        chk("sb_plain", {12'd0, op}, {12'd0, e.p});
        last_b = ob;
        last_p = op;
      end
    end
    if (!rst && out_valid_b && !prev_ov) chk("latency", cyc - acc_cyc, 16);
    prev_ov = out_valid_b;
  endtask

  task automatic send(input logic [15:0] v);
    bit h = 1'b0;
    in_valid = 1'b1;
    in_bin   = v;
    for (int i = 0; i < 100 && !h; i++) begin
      h = in_ready_b;
      tick();
    end
    if (!h) chk("accept_timeout", 0, 1);
    in_valid = 1'b0;
    in_bin   = 16'($urandom);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 60 && sb.size() != 0; i++) tick();
    chk("drain_timeout", sb.size(), 0);
    sb.delete();
  endtask

  vec_t tab[11];

  initial begin
    tab[0]  = '{16'd0,     20'hFFFF0, 20'h00000};
    tab[1]  = '{16'd65535, 20'h65535, 20'h65535};
    tab[2]  = '{16'd1234,  20'hF1234, 20'h01234};
    tab[3]  = '{16'd1000,  20'hF1000, 20'h01000};
    tab[4]  = '{16'd42,    20'hFFF42, 20'h00042};
    tab[5]  = '{16'd10,    20'hFFF10, 20'h00010};
    tab[6]  = '{16'd60009, 20'h60009, 20'h60009};
    tab[7]  = '{16'd1,     20'hFFFF1, 20'h00001};
    tab[8]  = '{16'd5,     20'hFFFF5, 20'h00005};
    tab[9]  = '{16'd99,    20'hFFF99, 20'h00099};
    tab[10] = '{16'd100,   20'hFF100, 20'h00100};

    rst = 1'b1; in_valid = 1'b0; in_bin = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'd0, out_valid_b}, 0);
    chk("rst_out_bcd",   {12'd0, out_bcd_b}, 0);
    chk("rst_in_ready",  {31'd0, in_ready_b}, 1);
    rst = 1'b0;
    tick();

    // Directed table
    foreach (tab[i]) begin
      send(tab[i].bin);
      drain();
      chk("tab_blank", {12'd0, last_b}, {12'd0, tab[i].b});
      chk("tab_plain", {12'd0, last_p}, {12'd0, tab[i].p});
    end

    // Backpressure with ignored input pulses during SHIFT/DONE
    out_ready = 1'b0;
    send(16'd1234);
    for (int i = 0; i < 40 && !out_valid_b; i++) begin
      in_valid = 1'($urandom);
      in_bin   = 16'($urandom);
      tick();
    end
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'($urandom);
      in_bin   = 16'($urandom);
      tick();
      chk("bp_out_valid", {31'd0, out_valid_b}, 1);
      chk("bp_out_bcd",   {12'd0, out_bcd_b}, 32'h000F1234);
      chk("bp_in_ready",  {31'd0, in_ready_b}, 0);
    end
    in_valid = 1'b0;
    drain();
    chk("bp_result",     {12'd0, last_b}, 32'h000F1234);
    chk("post_in_ready", {31'd0, in_ready_b}, 1);
    chk("post_out_vld",  {31'd0, out_valid_b}, 0);

    // Reset at SHIFT cycle 7
    send(16'd12345);
    repeat (6) tick();
    rst = 1'b1;
    #1;
    chk("arst_out_valid", {31'd0, out_valid_b}, 0);
    chk("arst_out_bcd",   {12'd0, out_bcd_b}, 0);
    chk("arst_in_ready",  {31'd0, in_ready_b}, 1);
    sb.delete();
    prev_ov = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    begin
      bit stale = 1'b0;
      for (int i = 0; i < 25; i++) begin
        tick();
        if (out_valid_b) stale = 1'b1;
      end
      chk("no_stale_valid", {31'd0, stale}, 0);
    end
    send(16'd9);
    drain();
    chk("post_rst_result", {12'd0, last_b}, 32'h000FFFF9);

    // Back-to-back throughput
    acc_q.delete();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 80; i++) begin
      in_bin = 16'($urandom);
      tick();
    end
    in_valid = 1'b0;
    drain();
    chk("b2b_count_ge4", {31'd0, acc_q.size() >= 4}, 1);
    for (int i = 1; i < acc_q.size(); i++)
      chk("b2b_spacing", acc_q[i] - acc_q[i-1], 18);

    // Random sweep against the model
    for (int i = 0; i < 1500; i++) begin
      send(16'($urandom));
      drain();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
